// File: rtl/btn_debounce_pulse.sv
// -----------------------------------------------------------------------------
// btn_debounce_pulse
//
// Turns a raw, bouncy, asynchronous push-button into clean single-cycle
// strobes for the counter stage that follows it.
//
//   raw btn_in -> SYNC_STAGES flop synchronizer -> btn_sync
//   btn_sync   -> 4-state debounce FSM with stability counter (db_cnt)
//   FSM        -> btn_level, press_pulse, release_pulse
//   HIGH time  -> hold counter (hold_cnt) -> hold_pulse
//
// Ports:
//   clk            clock
//   rst            asynchronous, active-high reset
//   clr            synchronous clear: FSM to LOW, counters to 0, no pulses
//   btn_in         raw button input, asynchronous to clk, active-high
//   btn_level      debounced level (1 in HIGH and WAIT_L)
//   press_pulse    one cycle after an accepted 0->1
//   release_pulse  one cycle after an accepted 1->0
//   hold_pulse     one cycle, HOLD_CNT cycles after press_pulse, once per press
//
// Output handshake: there is no valid/ready pairing here. Every output is a
// register; the pulses are plain one-cycle strobes that the downstream counter
// samples on its next clock edge with no back-pressure.
//
// Internal FSM state is held in the signal `state` (type state_t) for
// binding checkers.
// -----------------------------------------------------------------------------
module btn_debounce_pulse #(
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CNT  = 50000,
  parameter int DB_WIDTH    = 16,
  parameter int HOLD_CNT    = 1000000,
  parameter int HOLD_WIDTH  = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic hold_pulse
);

  typedef enum logic [1:0] {
    S_LOW    = 2'd0,
    S_WAIT_H = 2'd1,
    S_HIGH   = 2'd2,
    S_WAIT_L = 2'd3
  } state_t;

  // The hold counter gets one spare bit so HOLD_CNT == 2**HOLD_WIDTH is
  // still representable as the saturation value.
  localparam int HW = HOLD_WIDTH + 1;

  localparam logic [DB_WIDTH-1:0] DB_LAST   = DB_WIDTH'(STABLE_CNT - 1);
  localparam logic [DB_WIDTH-1:0] DB_ONE    = DB_WIDTH'(1);
  localparam logic [HW-1:0]       HOLD_MAX  = HW'(HOLD_CNT);
  localparam logic [HW-1:0]       HOLD_LAST = HW'(HOLD_CNT - 1);
  localparam logic [HW-1:0]       HOLD_ONE  = HW'(1);

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_sync;
  logic [DB_WIDTH-1:0]    db_cnt;
  logic [HW-1:0]          hold_cnt;
  logic                   in_high_time;

  // ---------------------------------------------------------------------------
  // Synchronizer. Not touched by clr: the synchronizer just tracks the pin, so
  // a press still held through clr is re-accepted after only the FSM latency.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
    end
  end

  assign btn_sync = sync_q[SYNC_STAGES-1];

  // The hold counter runs while the debounced level is high, which includes
  // WAIT_L so a release bounce does not restart the hold timing.
  assign in_high_time = (state == S_HIGH) || (state == S_WAIT_L);

  // ---------------------------------------------------------------------------
  // Debounce FSM, stability counter, hold counter and registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_LOW;
      db_cnt        <= '0;
      hold_cnt      <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      hold_pulse    <= 1'b0;
    end else if (clr) begin
      state         <= S_LOW;
      db_cnt        <= '0;
      hold_cnt      <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      hold_pulse    <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      hold_pulse    <= 1'b0;

      case (state)
        S_LOW: begin
          hold_cnt <= '0;
          if (btn_sync) begin
            state  <= S_WAIT_H;
            db_cnt <= '0;
          end
        end

        S_WAIT_H: begin
          if (!btn_sync) begin
            // Too short: glitch, drop back without any pulse.
            state <= S_LOW;
          end else if (db_cnt == DB_LAST) begin
            state       <= S_HIGH;
            btn_level   <= 1'b1;
            press_pulse <= 1'b1;
            hold_cnt    <= '0;
          end else begin
            db_cnt <= db_cnt + DB_ONE;
          end
        end

        S_HIGH: begin
          if (!btn_sync) begin
            state  <= S_WAIT_L;
            db_cnt <= '0;
          end
        end

        S_WAIT_L: begin
          if (btn_sync) begin
            // Release bounce: back to HIGH, level never dropped.
            state <= S_HIGH;
          end else if (db_cnt == DB_LAST) begin
            state         <= S_LOW;
            btn_level     <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            db_cnt <= db_cnt + DB_ONE;
          end
        end

        default: begin
          state <= S_LOW;
        end
      endcase

      // Saturating hold counter; the pulse is emitted on the single step into
      // HOLD_CNT, so saturation alone guarantees at most one pulse per press.
      if (in_high_time && (hold_cnt != HOLD_MAX)) begin
        hold_cnt <= hold_cnt + HOLD_ONE;
        if (hold_cnt == HOLD_LAST) begin
          hold_pulse <= 1'b1;
        end
      end
    end
  end

endmodule
